// File: rtl/prescaled_counter.sv
`default_nettype none
// ============================================================================
//  Module      : prescaled_counter
//  Description : Up/down counter with a runtime divide-by-(i_div+1) prescaler,
//                a runtime inclusive top value, parallel load, and an optional
//                one-shot mode that stops at the terminal value.
//                Produces registered tick, change, wrap and done indications.
//  Revision    : 1.0 - initial release
// ============================================================================
module prescaled_counter #(
    parameter int WIDTH    = 8,
    parameter int DIV_W    = 4,
    parameter int ONE_SHOT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic [DIV_W-1:0] i_div,
    input  logic [WIDTH-1:0] i_top,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] value,
    output logic             o_tick,
    output logic             o_change,
    output logic             o_wrap,
    output logic             o_done
);

    localparam logic             c_one_shot = (ONE_SHOT != 0);
    localparam logic [DIV_W-1:0] c_pre_one  = DIV_W'(1);
    localparam logic [WIDTH-1:0] c_val_one  = WIDTH'(1);

    logic [DIV_W-1:0] r_pre;
    logic [WIDTH-1:0] r_value;
    logic             r_tick;
    logic             r_change;
    logic             r_wrap;
    logic             r_done;

    logic [DIV_W-1:0] w_next_pre;
    logic [WIDTH-1:0] w_next_value;
    logic             w_next_done;
    logic             w_next_tick;
    logic             w_next_wrap;
    logic             w_step;
    logic             w_at_term;

    // A step fires once the prescaler has reached the divide value; using >=
    // lets a lowered i_div take effect on the very next enabled cycle.
    assign w_step    = i_en && (r_pre >= i_div);
    // Terminal value depends on direction: top when counting up, zero when down.
    assign w_at_term = i_up ? (r_value >= i_top) : (r_value == '0);

    // Next-state computation: load beats step, step beats hold.
    always_comb begin
        w_next_pre   = r_pre;
        w_next_value = r_value;
        w_next_done  = r_done;
        w_next_tick  = 1'b0;
        w_next_wrap  = 1'b0;
        if (i_load) begin
            w_next_value = i_load_value;
            w_next_pre   = '0;
            w_next_done  = 1'b0;
        end else if (i_en) begin
            if (w_step) begin
                w_next_pre = '0;
                // Once a one-shot run has finished, steps are swallowed.
                if (!(c_one_shot && r_done)) begin
                    w_next_tick = 1'b1;
                    if (w_at_term) begin
                        if (c_one_shot) begin
                            w_next_done = 1'b1;
                        end else begin
                            w_next_value = i_up ? '0 : i_top;
                            w_next_wrap  = 1'b1;
                        end
                    end else begin
                        w_next_value = i_up ? (r_value + c_val_one)
                                            : (r_value - c_val_one);
                    end
                end
            end else begin
                w_next_pre = r_pre + c_pre_one;
            end
        end
    end

    // State and pulse registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre    <= '0;
            r_value  <= '0;
            r_tick   <= 1'b0;
            r_change <= 1'b0;
            r_wrap   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_pre    <= w_next_pre;
            r_value  <= w_next_value;
            r_tick   <= w_next_tick;
            r_change <= (w_next_value != r_value);
            r_wrap   <= w_next_wrap;
            r_done   <= w_next_done;
        end
    end

    assign value    = r_value;
    assign o_tick   = r_tick;
    assign o_change = r_change;
    assign o_wrap   = r_wrap;
    assign o_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prescaled_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prescaled_counter
//  Description : Self-checking bench for prescaled_counter. Two instances
//                (wrapping and one-shot) share stimulus; a behavioural model
//                checks both every cycle, and directed checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prescaled_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic [3:0] div;
    logic [7:0] top;
    logic       load;
    logic [7:0] lv;

    logic [7:0] value0, value1;
    logic       tick0, tick1, chg0, chg1, wrap0, wrap1, done0, done1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state, index 0 = wrapping instance, 1 = one-shot instance.
    int m_val  [2];
    int m_cnt  [2];
    int m_done [2];
    int m_tick [2];
    int m_chg  [2];
    int m_wrap [2];

    always #5 clk = ~clk;

    prescaled_counter #(.WIDTH(8), .DIV_W(4), .ONE_SHOT(0)) dut0 (
        .clk(clk), .rst(rst), .i_en(en), .i_up(up), .i_div(div), .i_top(top),
        .i_load(load), .i_load_value(lv), .value(value0), .o_tick(tick0),
        .o_change(chg0), .o_wrap(wrap0), .o_done(done0)
    );

    prescaled_counter #(.WIDTH(8), .DIV_W(4), .ONE_SHOT(1)) dut1 (
        .clk(clk), .rst(rst), .i_en(en), .i_up(up), .i_div(div), .i_top(top),
        .i_load(load), .i_load_value(lv), .value(value1), .o_tick(tick1),
        .o_change(chg1), .o_wrap(wrap1), .o_done(done1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: m_cnt counts enabled cycles since the last step or
    // load; the (i_div+1)-th one is a step.
    task automatic model_update(input int k);
        int old;
        bit os;
        os  = (k == 1);
        old = m_val[k];
        m_tick[k] = 0;
        m_wrap[k] = 0;
        if (rst) begin
            m_val[k]  = 0;
            m_cnt[k]  = 0;
            m_done[k] = 0;
            m_chg[k]  = 0;
        end else begin
            if (load) begin
                m_val[k]  = int'(lv);
                m_cnt[k]  = 0;
                m_done[k] = 0;
            end else if (en) begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] >= int'(div) + 1) begin
                    m_cnt[k] = 0;
                    if (!(os && m_done[k] != 0)) begin
                        m_tick[k] = 1;
                        if (up) begin
                            if (old >= int'(top)) begin
                                if (os) m_done[k] = 1;
                                else begin m_val[k] = 0; m_wrap[k] = 1; end
                            end else m_val[k] = old + 1;
                        end else begin
                            if (old == 0) begin
                                if (os) m_done[k] = 1;
                                else begin m_val[k] = int'(top); m_wrap[k] = 1; end
                            end else m_val[k] = old - 1;
                        end
                    end
                end
            end
            m_chg[k] = (m_val[k] != old) ? 1 : 0;
        end
    endtask

    // Every cycle: advance the model on the edge, compare shortly after.
    always begin
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        chk("m0_value",  int'(value0), m_val[0]);
        chk("m0_tick",   int'(tick0),  m_tick[0]);
        chk("m0_change", int'(chg0),   m_chg[0]);
        chk("m0_wrap",   int'(wrap0),  m_wrap[0]);
        chk("m0_done",   int'(done0),  m_done[0]);
        chk("m1_value",  int'(value1), m_val[1]);
        chk("m1_tick",   int'(tick1),  m_tick[1]);
        chk("m1_change", int'(chg1),   m_chg[1]);
        chk("m1_wrap",   int'(wrap1),  m_wrap[1]);
        chk("m1_done",   int'(done1),  m_done[1]);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int exp1 [5];
        exp1 = '{1, 2, 3, 0, 1};
        rst = 1'b1; en = 1'b0; up = 1'b1; div = 4'd0; top = 8'd3;
        load = 1'b0; lv = 8'd0;
        cyc(); cyc();
        chk("rst_value", int'(value0), 0);
        chk("rst_tick",  int'(tick0),  0);
        chk("rst_done",  int'(done1),  0);

        // Divide-by-1, top 3, counting up.
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t1_value", int'(value0), exp1[i]);
            chk("t1_wrap",  int'(wrap0),  (i == 3) ? 1 : 0);
            chk("t1_tick",  int'(tick0),  1);
        end

        // Divide-by-3, full range, enable gap stretches the period.
        div = 4'd2; top = 8'd255; load = 1'b1; lv = 8'd0;
        cyc();
        load = 1'b0;
        cyc(); cyc(); cyc();
        chk("t2_first_step", int'(value0), 1);
        chk("t2_first_tick", int'(tick0),  1);
        cyc();
        en = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        en = 1'b1;
        cyc();
        chk("t2_gap_value", int'(value0), 1);
        chk("t2_gap_tick",  int'(tick0),  0);
        cyc();
        chk("t2_gap_step",  int'(value0), 2);

        // Down count with load, then out-of-range load and an up step.
        div = 4'd0; top = 8'd5; up = 1'b0; load = 1'b1; lv = 8'd2;
        cyc();
        chk("t3_load", int'(value0), 2);
        load = 1'b0;
        cyc(); chk("t3_d1", int'(value0), 1);
        cyc(); chk("t3_d0", int'(value0), 0);
        cyc(); chk("t3_d5", int'(value0), 5);
        chk("t3_wrap5", int'(wrap0), 1);
        cyc(); chk("t3_d4", int'(value0), 4);
        load = 1'b1; lv = 8'd9;
        cyc(); chk("t3_load9", int'(value0), 9);
        load = 1'b0; up = 1'b1;
        cyc();
        chk("t3_over_value", int'(value0), 0);
        chk("t3_over_wrap",  int'(wrap0),  1);

        // One-shot run to top 2.
        top = 8'd2; load = 1'b1; lv = 8'd0;
        cyc();
        load = 1'b0;
        cyc(); chk("t4_v1", int'(value1), 1);
        cyc(); chk("t4_v2", int'(value1), 2);
        cyc();
        chk("t4_hold", int'(value1), 2);
        chk("t4_done", int'(done1),  1);
        chk("t4_nowrap", int'(wrap1), 0);
        cyc();
        chk("t4_tick_stop", int'(tick1), 0);
        up = 1'b0;
        cyc();
        chk("t4_done_dir", int'(done1), 1);
        up = 1'b1; load = 1'b1; lv = 8'd0;
        cyc();
        chk("t4_reload_done", int'(done1), 0);
        load = 1'b0;
        cyc();
        chk("t4_resume", int'(value1), 1);

        // Top of zero: wrap every step with no value change.
        top = 8'd0; load = 1'b1; lv = 8'd0;
        cyc();
        load = 1'b0;
        cyc(); cyc();
        chk("t5_value",  int'(value0), 0);
        chk("t5_wrap",   int'(wrap0),  1);
        chk("t5_change", int'(chg0),   0);

        // Lowering i_div mid-count forces an immediate step.
        top = 8'd10; div = 4'd7; load = 1'b1; lv = 8'd0;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk("t5_pre_tick", int'(tick0), 0);
        div = 4'd1;
        cyc();
        chk("t5_div_value", int'(value0), 1);
        chk("t5_div_tick",  int'(tick0),  1);

        // Reset together with load in the same cycle.
        top = 8'd0; div = 4'd0;
        cyc(); cyc();
        chk("t6_done_set", int'(done1), 1);
        rst = 1'b1; load = 1'b1; lv = 8'd77; div = 4'd3; top = 8'd10;
        cyc();
        chk("t6_value", int'(value0), 0);
        chk("t6_done",  int'(done1),  0);
        chk("t6_wrap",  int'(wrap0),  0);
        rst = 1'b0; load = 1'b0;
        cyc(); cyc(); cyc();
        chk("t6_nostep", int'(value0), 0);
        cyc();
        chk("t6_step", int'(value0), 1);
        chk("t6_tick", int'(tick0),  1);

        // Mixed sequence checked by the model alone.
        for (int i = 0; i < 300; i++) begin
            en   = ($urandom_range(0, 7) != 0);
            up   = 1'($urandom_range(0, 1));
            div  = 4'($urandom_range(0, 3));
            top  = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
            load = ($urandom_range(0, 15) == 0);
            lv   = 8'($urandom_range(0, 15));
            rst  = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst = 1'b0; load = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prescaled_counter.md
# prescaled_counter

Runtime-programmable up/down counter with an integrated prescaler, modulus, parallel load and a one-shot mode. It replaces fixed power-of-two division and compile-time limits with divide-by-(N+1) and a runtime top value, and adds wrap, tick and done indications. It is the general timing and counting primitive for iCE40 designs: PWM periods, timeouts, baud and refresh timers, and event counters.

## Interface
- WIDTH, 8, counter width in bits
- DIV_W, 4, prescaler register width; division ratio is i_div+1, from 1 to 2^DIV_W
- ONE_SHOT, 0, 0 = wrap at the limit; 1 = stop at the limit and assert o_done

- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- i_en  in  1  count enable; when 0, the prescaler and counter hold
- i_up  in  1  direction: 1 = up, 0 = down; sampled on each step
- i_div  in  DIV_W  prescale value; one step every i_div+1 enabled cycles
- i_top  in  WIDTH  inclusive upper limit; count range is 0..i_top
- i_load  in  1  parallel load strobe
- i_load_value  in  WIDTH  value to load
- value  out  WIDTH  current count (registered)
- o_tick  out  1  one-cycle pulse, high in the cycle a step takes effect
- o_change  out  1  one-cycle pulse, high in the cycle value differs from its previous value
- o_wrap  out  1  one-cycle pulse, high in the cycle value shows a wrap result
- o_done  out  1  level, ONE_SHOT only; high once the terminal value is reached

## Operation
- Reset: value=0, prescaler=0, o_tick=o_change=o_wrap=o_done=0. Reset overrides all other inputs.
- Priority per edge: rst > i_load > step > hold.
- Prescaler (pre, DIV_W bits):
  - Advances only when i_en=1 and i_load=0.
  - step = i_en && (pre >= i_div). On a step, pre <= 0; otherwise pre <= pre+1.
  - Using >= means a mid-count reduction of i_div causes a step on the next enabled cycle.
- Step, up (i_up=1):
  - If value >= i_top: value <= 0, o_wrap <= 1.
  - Otherwise value <= value+1.
- Step, down (i_up=0):
  - If value == 0: value <= i_top, o_wrap <= 1.
  - Otherwise value <= value-1.
- ONE_SHOT=1:
  - A step at the terminal value (up: value >= i_top; down: value == 0) does not wrap. value holds, o_done <= 1, o_wrap stays 0.
  - While o_done=1, steps are suppressed: o_tick=0 and value frozen. Changing i_up does not clear o_done.
- Load:
  - value <= i_load_value, pre <= 0, o_done <= 0, o_tick <= 0, o_wrap <= 0.
  - A loaded value above i_top is legal. The next up-step wraps to 0; down-steps decrement normally.
- o_tick <= step taken (not suppressed, no load).
- o_change <= (next value != value). This covers steps and loads. It stays 0 when i_top=0 wraps 0->0 and when a load writes the same value.
- Arithmetic is modulo 2^WIDTH. i_top=2^WIDTH-1 gives a full-range binary counter.

## Timing
- All outputs are registered. value, o_tick, o_change and o_wrap update on the same edge, so they are coherent within a cycle.
- With i_en held high, the first step after reset or load occurs at edge i_div+1. Steps then repeat every i_div+1 cycles.
- i_div=0: a step every enabled cycle; o_tick is high continuously.
- i_en low: pre and value freeze, and pulses drop to 0 on the next edge. When i_en returns high, prescaling resumes from the frozen pre.
- i_top or i_up changes take effect at the next step, with no restart.
- Load is one cycle. value shows i_load_value on the edge after the i_load strobe.

## Test plan
- Reset, WIDTH=8, i_div=0, i_top=3, up, i_en=1 -> value 1,2,3,0,1 on successive cycles. o_wrap high only in the cycle value=0; o_tick and o_change high every cycle.
- i_div=2, i_top=255, up -> value increments every 3rd cycle. o_tick has a 1-of-3 duty, and i_en low for 5 cycles extends the period by exactly 5.
- Down, i_top=5, load 2 -> loaded 2 appears the cycle after the strobe, then 1, 0, 5, 4 with o_wrap at 5. A load of 9 followed by an up-step gives 0 with o_wrap.
- ONE_SHOT=1, i_top=2, up -> 1, 2, then value holds 2, o_done=1, o_wrap never high, o_tick stops. Load 0 clears o_done and counting resumes.
- i_top=0, up, i_div=0 -> value stays 0, o_wrap every cycle, o_change=0. With i_div=7, reducing i_div to 1 at pre=5 gives a step on the next cycle.
- rst asserted mid-count with i_load=1 at the same edge -> value=0, all pulses 0, o_done=0, and the next step occurs i_div+1 cycles after rst falls.
